// File: rtl/nco_ctrl_pkg.sv
// Shared types and default widths for the NCO step scheduler and the NCO
// instantiation that consumes its step words.
package nco_ctrl_pkg;

  localparam int NCO_ACC_WIDTH   = 32;
  localparam int NCO_SEL_WIDTH   = 4;
  localparam int NCO_DWELL_WIDTH = 24;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_GLIDE  = 2'd1,
    MODE_SWEEP  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_EMIT  = 2'd2
  } state_e;

  // The reserved encoding behaves exactly like DIRECT so software never
  // lands the scheduler in an undefined mode.
  function automatic mode_e decodeMode(input logic [1:0] raw);
    mode_e m;
    m = mode_e'(raw);
    if (m == MODE_RSVD) m = MODE_DIRECT;
    return m;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Down-counter that measures the dwell period between step updates.
// A load of zero is treated as one so the period is never empty.
module dwell_timer
  import nco_ctrl_pkg::*;
#(
  parameter int DWELL_WIDTH = NCO_DWELL_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rstN,
  input  logic                   i_load,
  input  logic                   i_count,
  input  logic [DWELL_WIDTH-1:0] i_dwell,
  output logic                   o_expire
);

  logic [DWELL_WIDTH-1:0] r_count;

  // Load the period on request, then step down towards one while counting.
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= (i_dwell == '0) ? DWELL_WIDTH'(1) : i_dwell;
    end else if (i_count && (r_count > DWELL_WIDTH'(1))) begin
      r_count <= r_count - DWELL_WIDTH'(1);
    end
  end

  assign o_expire = i_count && (r_count <= DWELL_WIDTH'(1));

endmodule

// File: rtl/nco_step_scheduler.sv
// Produces the phase-step word for the NCO: a registered target of
// ref_step * index, reached directly, by bounded glide, or by auto-sweep,
// with one AXI-Stream beat per change of the current step.
module nco_step_scheduler
  import nco_ctrl_pkg::*;
#(
  parameter int ACC_WIDTH   = NCO_ACC_WIDTH,
  parameter int SEL_WIDTH   = NCO_SEL_WIDTH,
  parameter int DWELL_WIDTH = NCO_DWELL_WIDTH
) (
  input  logic                   aclk,
  input  logic                   arst_n,
  input  logic [1:0]             cfg_mode,
  input  logic [SEL_WIDTH-1:0]   cfg_sel,
  input  logic [ACC_WIDTH-1:0]   cfg_ref_step,
  input  logic [ACC_WIDTH-1:0]   cfg_slew,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic [SEL_WIDTH-1:0]   cfg_sweep_lo,
  input  logic [SEL_WIDTH-1:0]   cfg_sweep_hi,
  output logic [ACC_WIDTH-1:0]   m_axis_step_tdata,
  output logic                   m_axis_step_tvalid,
  input  logic                   m_axis_step_tready,
  output logic                   busy,
  output logic                   settled
);

  mode_e                w_mode;
  state_e               r_state;
  state_e               w_stateNext;

  logic [SEL_WIDTH-1:0] w_idx;
  logic [SEL_WIDTH-1:0] r_lastIdx;
  logic [SEL_WIDTH-1:0] r_sweepIdx;
  logic [SEL_WIDTH-1:0] w_sweepNext;
  logic                 r_inSweep;
  logic                 w_sweepReload;
  logic                 w_sweepAdvance;
  logic                 w_targetStale;

  logic [ACC_WIDTH-1:0] r_target;
  logic [ACC_WIDTH-1:0] r_curStep;
  logic [ACC_WIDTH-1:0] w_curNext;
  logic                 w_curLoad;

  logic                 w_up;
  logic [ACC_WIDTH-1:0] w_diff;
  logic [ACC_WIDTH-1:0] w_stepAmt;
  logic [ACC_WIDTH-1:0] w_glideNext;

  logic                 r_dwellSweep;
  logic                 w_dwellLoad;
  logic                 w_dwellCount;
  logic                 w_dwellExpire;

  assign w_mode = decodeMode(cfg_mode);
  assign w_idx  = (w_mode == MODE_SWEEP) ? r_sweepIdx : cfg_sel;

  // Sweep bookkeeping: the index the sweep should move to next, and whether
  // the current index must be snapped back to lo (fresh entry into SWEEP, or
  // an index outside the range; with lo>hi the only legal index is lo).
  always_comb begin
    w_sweepNext   = cfg_sweep_lo;
    w_sweepReload = 1'b0;
    if ((cfg_sweep_lo <= cfg_sweep_hi) && (r_sweepIdx < cfg_sweep_hi) &&
        (r_sweepIdx >= cfg_sweep_lo)) begin
      w_sweepNext = r_sweepIdx + SEL_WIDTH'(1);
    end
    if (w_mode == MODE_SWEEP) begin
      if (!r_inSweep) begin
        w_sweepReload = 1'b1;
      end else if (cfg_sweep_lo <= cfg_sweep_hi) begin
        w_sweepReload = (r_sweepIdx < cfg_sweep_lo) || (r_sweepIdx > cfg_sweep_hi);
      end else begin
        w_sweepReload = (r_sweepIdx != cfg_sweep_lo);
      end
    end
  end

  // The registered target lags the index by one cycle; while they disagree
  // the idle decision waits so it never acts on a stale product.
  assign w_targetStale = (r_lastIdx != w_idx);

  // Glide arithmetic: move towards the target by at most slew, landing
  // exactly on it when the remaining distance is smaller (slew 0 jumps).
  always_comb begin
    w_up        = (r_target > r_curStep);
    w_diff      = w_up ? (r_target - r_curStep) : (r_curStep - r_target);
    w_stepAmt   = ((cfg_slew == '0) || (cfg_slew >= w_diff)) ? w_diff : cfg_slew;
    w_glideNext = w_up ? (r_curStep + w_stepAmt) : (r_curStep - w_stepAmt);
  end

  // Target product and index tracking, recomputed every cycle.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      r_target  <= '0;
      r_lastIdx <= '0;
      r_inSweep <= 1'b0;
    end else begin
      r_target  <= cfg_ref_step * {{(ACC_WIDTH-SEL_WIDTH){1'b0}}, w_idx};
      r_lastIdx <= w_idx;
      r_inSweep <= (w_mode == MODE_SWEEP);
    end
  end

  // Sweep index: a snap to lo takes priority over the periodic advance.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      r_sweepIdx <= '0;
    end else if (w_sweepReload) begin
      r_sweepIdx <= cfg_sweep_lo;
    end else if (w_sweepAdvance) begin
      r_sweepIdx <= w_sweepNext;
    end
  end

  // Current step and the mode that owns the running dwell period, so a mode
  // change only takes effect at the next idle decision.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      r_curStep    <= '0;
      r_dwellSweep <= 1'b0;
    end else begin
      if (w_curLoad) r_curStep <= w_curNext;
      if (w_dwellLoad) r_dwellSweep <= (w_mode == MODE_SWEEP);
    end
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (!arst_n) r_state <= S_IDLE;
    else         r_state <= w_stateNext;
  end

  // Next-state and control decode; beats are only ever left via handshake.
  always_comb begin
    w_stateNext        = r_state;
    w_curLoad          = 1'b0;
    w_curNext          = r_curStep;
    w_dwellLoad        = 1'b0;
    w_dwellCount       = 1'b0;
    w_sweepAdvance     = 1'b0;
    m_axis_step_tvalid = 1'b0;
    busy               = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        if (!w_targetStale && !w_sweepReload) begin
          if (r_target != r_curStep) begin
            if (w_mode == MODE_GLIDE) begin
              w_dwellLoad = 1'b1;
              w_stateNext = S_DWELL;
            end else begin
              w_curLoad   = 1'b1;
              w_curNext   = r_target;
              w_stateNext = S_EMIT;
            end
          end else if (w_mode == MODE_SWEEP) begin
            w_dwellLoad = 1'b1;
            w_stateNext = S_DWELL;
          end
        end
      end
      S_DWELL: begin
        w_dwellCount = 1'b1;
        if (w_dwellExpire) begin
          if (r_dwellSweep) begin
            w_sweepAdvance = 1'b1;
            w_stateNext    = S_IDLE;
          end else if (r_target == r_curStep) begin
            w_stateNext = S_IDLE;
          end else begin
            w_curLoad   = 1'b1;
            w_curNext   = w_glideNext;
            w_stateNext = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        m_axis_step_tvalid = 1'b1;
        if (m_axis_step_tready) w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  assign m_axis_step_tdata = r_curStep;
  assign settled           = (r_curStep == r_target) && (r_state != S_EMIT);

  dwell_timer #(
    .DWELL_WIDTH (DWELL_WIDTH)
  ) u_dwellTimer (
    .i_clk    (aclk),
    .i_rstN   (arst_n),
    .i_load   (w_dwellLoad),
    .i_count  (w_dwellCount),
    .i_dwell  (cfg_dwell),
    .o_expire (w_dwellExpire)
  );

endmodule
